// File: rtl/leg_seq_decoder_pkg.sv
// Shared types and helpers for leg_seq_decoder (package leg_dec_pkg).
// The state enum, the one-hot helper and the parameter-legality check live here so the decoder and bench agree on them.
package leg_dec_pkg;

  localparam int MAX_OUT = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } dec_state_t;

  // Out-of-range indices produce an all-zero vector rather than wrapping.
  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n);
    if (idx < n && idx < MAX_OUT) return 64'(1) << idx;
    return '0;
  endfunction

  function automatic bit params_ok(input int sel_w, input int num_out, input int dwell);
    return (sel_w >= 1) && (sel_w <= 6) && (num_out >= 2) &&
           (num_out <= (1 << sel_w)) && (dwell >= 1) && (dwell <= 255);
  endfunction

endpackage

// File: rtl/leg_seq_decoder_if.sv
// Control and strobe bundle between instruction decode and the decoder.
// The range_err signal exists only when LEG_DEC_RANGE_ERR_EN is defined.
interface leg_seq_decoder_if #(
  parameter int SEL_W   = 4,
  parameter int NUM_OUT = 16
);
  import leg_dec_pkg::*;

  // Requests are single-cycle samples with no ready: dec_en/sweep_start are
  // acted on only in IDLE with dis low, otherwise dropped. out_valid is high
  // exactly when the registered out is nonzero; nothing back-pressures it.
  logic [SEL_W-1:0]   sel;
  logic               dec_en;
  logic               dis;
  logic               sweep_start;
  logic [NUM_OUT-1:0] out;
  logic               out_valid;
  logic               sweep_busy;
  logic               sweep_done;
  dec_state_t         dbg_state;
`ifdef LEG_DEC_RANGE_ERR_EN
  logic               range_err;
`endif

  modport master (
    output sel, dec_en, dis, sweep_start,
    input  out, out_valid, sweep_busy, sweep_done, dbg_state
`ifdef LEG_DEC_RANGE_ERR_EN
    , input range_err
`endif
  );

  modport slave (
    input  sel, dec_en, dis, sweep_start,
    output out, out_valid, sweep_busy, sweep_done, dbg_state
`ifdef LEG_DEC_RANGE_ERR_EN
    , output range_err
`endif
  );

endinterface

// File: rtl/leg_dwell_counter.sv
// Loadable up-counter with freeze (en low) and a terminal-count flag; wraps to zero after TERM.
module leg_dwell_counter #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   TERM = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == TERM);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/leg_seq_decoder.sv
// Registered one-hot decoder with a boot-time sweep that walks every output in turn.
// Define LEG_DEC_RANGE_ERR_EN to add the range_err pulse for out-of-range selects.
module leg_seq_decoder
  import leg_dec_pkg::*;
#(
  parameter int SEL_W       = 4,
  parameter int NUM_OUT     = 16,
  parameter int HOLD_MODE   = 0,
  parameter int SWEEP_DWELL = 1
) (
  input  logic              clk,
  input  logic              rst,
  leg_seq_decoder_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_OUT);
  localparam int DW_W  = 8;

  if (!params_ok(SEL_W, NUM_OUT, SWEEP_DWELL)) begin : g_bad_params
    $error("leg_seq_decoder: illegal SEL_W/NUM_OUT/SWEEP_DWELL combination");
  end

  dec_state_t         state, state_next;
  logic [NUM_OUT-1:0] out_q, out_next;
  logic               out_valid_q, busy_q, done_q;
  logic               clear_cnt, advance, last_slot, sel_ok;
  logic [IDX_W-1:0]   idx;
  logic               idx_tc;
  logic [DW_W-1:0]    dwell;
  logic               dwell_tc;
  logic [31:0]        idx_after;

  leg_dwell_counter #(.W(DW_W), .TERM(DW_W'(SWEEP_DWELL - 1))) u_dwell (
    .clk(clk), .rst(rst), .load(clear_cnt), .load_val('0),
    .en(advance), .count(dwell), .tc(dwell_tc)
  );

  leg_dwell_counter #(.W(IDX_W), .TERM(IDX_W'(NUM_OUT - 1))) u_idx (
    .clk(clk), .rst(rst), .load(clear_cnt), .load_val('0),
    .en(advance && dwell_tc), .count(idx), .tc(idx_tc)
  );

  assign sel_ok    = 32'(bus.sel) < 32'(NUM_OUT);
  assign last_slot = idx_tc && dwell_tc;
  assign idx_after = dwell_tc ? 32'(idx) + 32'd1 : 32'(idx);

  // In SWEEP a nonzero out means the current slot was shown this cycle, so it
  // is credited at the edge even if dis rises; a frozen cycle credits nothing.
  always_comb begin
    state_next = state;
    out_next   = '0;
    clear_cnt  = 1'b0;
    advance    = 1'b0;
    unique case (state)
      S_IDLE: begin
        clear_cnt = 1'b1;
        if (bus.dis) begin
          out_next = '0;
        end else if (bus.sweep_start) begin
          state_next = S_SWEEP;
          out_next   = NUM_OUT'(onehot(0, NUM_OUT));
        end else if (bus.dec_en) begin
          if (sel_ok) out_next = NUM_OUT'(onehot(32'(bus.sel), NUM_OUT));
        end else if (HOLD_MODE != 0) begin
          out_next = out_q;
        end
      end
      S_SWEEP: begin
        if (out_valid_q) begin
          advance = 1'b1;
          if (last_slot) state_next = S_DONE;
          else if (!bus.dis) out_next = NUM_OUT'(onehot(idx_after, NUM_OUT));
        end else if (!bus.dis) begin
          out_next = NUM_OUT'(onehot(32'(idx), NUM_OUT));
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        clear_cnt  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      out_q       <= out_next;
      out_valid_q <= |out_next;
      busy_q      <= (state_next != S_IDLE);
      done_q      <= (state_next == S_DONE);
    end
  end

  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sweep_busy = busy_q;
  assign bus.sweep_done = done_q;
  assign bus.dbg_state  = state;

`ifdef LEG_DEC_RANGE_ERR_EN
  logic range_err_q;

  always_ff @(posedge clk) begin
    if (!rst) range_err_q <= 1'b0;
    else      range_err_q <= (state == S_IDLE) && !bus.dis && !bus.sweep_start &&
                             bus.dec_en && !sel_ok;
  end

  assign bus.range_err = range_err_q;
`endif

endmodule

// File: tb/tb_leg_seq_decoder.sv
// Bench for leg_seq_decoder: three instances (pulse/dwell 2, hold, 12 outputs) checked
// against a slot-counting reference model, a vector table and directed sweep sequences.
`timescale 1ns/1ps
module tb_leg_seq_decoder;

  typedef struct {
    logic [3:0] sel;
    logic       dec_en;
    logic       dis;
    logic       start;
  } stim_t;

  typedef struct {
    int          phase;   // 0 idle, 1 sweeping, 2 done cycle
    int          k;       // sweep slots already shown
    bit          shown;
    logic [63:0] out;
    bit          busy;
    bit          done;
    bit          rerr;
  } mdl_t;

  typedef struct {
    logic [3:0]  sel;
    logic        dec_en;
    logic        dis;
    logic        start;
    logic [15:0] exp_out;
    logic        exp_busy;
  } vec_t;

  localparam int P_N[3] = '{16, 16, 12};
  localparam int P_H[3] = '{0, 1, 0};
  localparam int P_D[3] = '{2, 1, 1};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  stim_t st[3];
  mdl_t  m[3];
  int    n_checks = 0;
  int    n_errors = 0;
  logic [15:0] exp_q[$];

  leg_seq_decoder_if #(.SEL_W(4), .NUM_OUT(16)) if0();
  leg_seq_decoder_if #(.SEL_W(4), .NUM_OUT(16)) if1();
  leg_seq_decoder_if #(.SEL_W(4), .NUM_OUT(12)) if2();

  assign if0.sel = st[0].sel;  assign if0.dec_en = st[0].dec_en;
  assign if0.dis = st[0].dis;  assign if0.sweep_start = st[0].start;
  assign if1.sel = st[1].sel;  assign if1.dec_en = st[1].dec_en;
  assign if1.dis = st[1].dis;  assign if1.sweep_start = st[1].start;
  assign if2.sel = st[2].sel;  assign if2.dec_en = st[2].dec_en;
  assign if2.dis = st[2].dis;  assign if2.sweep_start = st[2].start;

  leg_seq_decoder #(.SEL_W(4), .NUM_OUT(16), .HOLD_MODE(0), .SWEEP_DWELL(2)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  leg_seq_decoder #(.SEL_W(4), .NUM_OUT(16), .HOLD_MODE(1), .SWEEP_DWELL(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  leg_seq_decoder #(.SEL_W(4), .NUM_OUT(12), .HOLD_MODE(0), .SWEEP_DWELL(1)) u2 (
    .clk(clk), .rst(rst), .bus(if2));

  // ---------------- reference model ----------------
  function automatic mdl_t model_reset();
    mdl_t r;
    r.phase = 0; r.k = 0; r.shown = 0; r.out = '0;
    r.busy = 0; r.done = 0; r.rerr = 0;
    return r;
  endfunction

  // A sweep is n*dwell display slots; slot k lights bit k/dwell. A shown cycle
  // earns one slot; a disabled cycle shows nothing and earns nothing.
  function automatic mdl_t model_step(mdl_t cur, stim_t s, logic rst_n, int n, int hold, int dwell);
    mdl_t r;
    r = cur;
    r.done = 0;
    r.rerr = 0;
    if (!rst_n) return model_reset();
    case (cur.phase)
      0: begin
        if (s.dis) r.out = '0;
        else if (s.start) begin
          r.phase = 1; r.k = 0; r.out = 64'd1; r.shown = 1;
        end else if (s.dec_en) begin
          if (int'(s.sel) < n) r.out = 64'd1 << s.sel;
          else begin r.out = '0; r.rerr = 1; end
        end else if (hold == 0) r.out = '0;
      end
      1: begin
        if (cur.shown) r.k = cur.k + 1;
        if (r.k == n * dwell) begin
          r.phase = 2; r.out = '0; r.shown = 0; r.done = 1;
        end else if (s.dis) begin
          r.out = '0; r.shown = 0;
        end else begin
          r.out = 64'd1 << (r.k / dwell); r.shown = 1;
        end
      end
      default: begin r.phase = 0; r.out = '0; end
    endcase
    r.busy = (r.phase != 0);
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [63:0] a_out, input logic a_v,
                           input logic a_b, input logic a_d);
    chk($sformatf("dut%0d out", d), a_out, m[d].out);
    chk($sformatf("dut%0d out_valid", d), 64'(a_v), 64'(m[d].out != 0));
    chk($sformatf("dut%0d sweep_busy", d), 64'(a_b), 64'(m[d].busy));
    chk($sformatf("dut%0d sweep_done", d), 64'(a_d), 64'(m[d].done));
    chk($sformatf("dut%0d onehot0", d), 64'($onehot0(a_out)), 64'd1);
  endtask

  task automatic check_all();
    check_dut(0, 64'(if0.out), if0.out_valid, if0.sweep_busy, if0.sweep_done);
    check_dut(1, 64'(if1.out), if1.out_valid, if1.sweep_busy, if1.sweep_done);
    check_dut(2, 64'(if2.out), if2.out_valid, if2.sweep_busy, if2.sweep_done);
`ifdef LEG_DEC_RANGE_ERR_EN
    chk("dut0 range_err", 64'(if0.range_err), 64'(m[0].rerr));
    chk("dut1 range_err", 64'(if1.range_err), 64'(m[1].rerr));
    chk("dut2 range_err", 64'(if2.range_err), 64'(m[2].rerr));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 3; d++) m[d] = model_step(m[d], st[d], rst, P_N[d], P_H[d], P_D[d]);
    #1;
    check_all();
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      st[d].sel = '0; st[d].dec_en = 1'b0; st[d].dis = 1'b0; st[d].start = 1'b0;
    end
  endtask

  task automatic rand_stim(input int d);
    st[d].sel    = 4'($urandom_range(0, 15));
    st[d].dec_en = 1'($urandom_range(0, 1));
    st[d].dis    = ($urandom_range(0, 4) == 0);
    st[d].start  = ($urandom_range(0, 15) == 0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[9];
  int   bit_cnt[16];
  int   done_cyc;
  int   cyc;
  int   pause_left;
  bit   paused;
  logic [15:0] last_out;

  initial begin
    tbl[0] = '{4'd5,  1'b1, 1'b0, 1'b0, 16'h0020, 1'b0};
    tbl[1] = '{4'd5,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{4'd15, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b0};
    tbl[3] = '{4'd0,  1'b1, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[4] = '{4'd3,  1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[5] = '{4'd7,  1'b1, 1'b0, 1'b0, 16'h0080, 1'b0};
    tbl[6] = '{4'd7,  1'b1, 1'b0, 1'b0, 16'h0080, 1'b0};
    tbl[7] = '{4'd9,  1'b0, 1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[8] = '{4'd2,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};

    for (int d = 0; d < 3; d++) m[d] = model_reset();
    idle_all();

    // Reset held 3 cycles under random inputs.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 3; d++) rand_stim(d);
      step();
      chk("reset out", 64'(if0.out), 64'd0);
      chk("reset out_valid", 64'(if0.out_valid), 64'd0);
      chk("reset sweep_busy", 64'(if0.sweep_busy), 64'd0);
      chk("reset sweep_done", 64'(if0.sweep_done), 64'd0);
    end
    idle_all();
    rst = 1'b1;
    step();

    // Pulse-mode decode table on dut0.
    for (int i = 0; i < 9; i++) begin
      st[0].sel = tbl[i].sel; st[0].dec_en = tbl[i].dec_en;
      st[0].dis = tbl[i].dis; st[0].start = tbl[i].start;
      step();
      chk($sformatf("table[%0d] out", i), 64'(if0.out), 64'(tbl[i].exp_out));
      chk($sformatf("table[%0d] busy", i), 64'(if0.sweep_busy), 64'(tbl[i].exp_busy));
    end
    idle_all();

    // Hold mode on dut1: 5 holds until the cycle after the decode of 9.
    st[1].sel = 4'd5; st[1].dec_en = 1'b1;
    step();
    chk("hold first", 64'(if1.out), 64'h0020);
    st[1].dec_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold keep", 64'(if1.out), 64'h0020);
    end
    st[1].sel = 4'd9; st[1].dec_en = 1'b1;
    step();
    chk("hold second", 64'(if1.out), 64'h0200);
    st[1].dec_en = 1'b0; st[1].dis = 1'b1;
    step();
    chk("hold dis clears", 64'(if1.out), 64'h0);
    idle_all();
    step();

    // Out-of-range select on dut2 (12 outputs).
    st[2].sel = 4'd13; st[2].dec_en = 1'b1;
    step();
    chk("oob out", 64'(if2.out), 64'h0);
`ifdef LEG_DEC_RANGE_ERR_EN
    chk("oob range_err pulse", 64'(if2.range_err), 64'd1);
`endif
    st[2].dec_en = 1'b0;
    step();
`ifdef LEG_DEC_RANGE_ERR_EN
    chk("oob range_err clears", 64'(if2.range_err), 64'd0);
`endif
    st[2].sel = 4'd11; st[2].dec_en = 1'b1;
    step();
    chk("top in-range", 64'(if2.out), 64'h0800);
    idle_all();
    step();

    // Sweep on dut0 (dwell 2) with a 3-cycle dis pause while bit 7 is lit.
    exp_q.delete();
    for (int b = 0; b < 16; b++) begin
      bit_cnt[b] = 0;
      for (int r = 0; r < 2; r++) exp_q.push_back(16'(1) << b);
    end
    st[0].start = 1'b1;
    step();
    st[0].start = 1'b0;
    cyc = 1; done_cyc = -1; pause_left = 0; paused = 1'b0;
    while (cyc < 100 && done_cyc < 0) begin
      if (if0.out != 0) begin
        if (exp_q.size() == 0) chk("sweep extra strobe", 64'(if0.out), 64'h0);
        else chk("sweep order", 64'(if0.out), 64'(exp_q.pop_front()));
        for (int b = 0; b < 16; b++) if (if0.out[b]) bit_cnt[b]++;
      end
      if (if0.sweep_done) done_cyc = cyc;
      if (!paused && if0.out == 16'h0080) begin paused = 1'b1; pause_left = 3; end
      st[0].dis = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      if (done_cyc < 0) begin
        step();
        cyc++;
      end
    end
    chk("sweep done cycle", 64'(done_cyc), 64'(16 * 2 + 1 + 3));
    chk("sweep queue drained", 64'(exp_q.size()), 64'd0);
    for (int b = 0; b < 16; b++) chk($sformatf("sweep bit%0d cycles", b), 64'(bit_cnt[b]), 64'd2);
    idle_all();
    step();

    // sweep_start beats dec_en; then reset aborts the sweep at idx 10.
    st[0].start = 1'b1; st[0].dec_en = 1'b1; st[0].sel = 4'd3;
    step();
    chk("simul starts at bit0", 64'(if0.out), 64'h0001);
    chk("simul busy", 64'(if0.sweep_busy), 64'd1);
    st[0].start = 1'b0;
    last_out = if0.out;
    cyc = 0;
    while (cyc < 60 && if0.out != 16'h0400) begin
      step();
      if (if0.out != 0) chk("simul monotonic", 64'(if0.out >= last_out), 64'd1);
      if (if0.out != 0) last_out = if0.out;
      cyc++;
    end
    chk("simul reached idx10", 64'(if0.out), 64'h0400);
    rst = 1'b0;
    step();
    chk("abort out", 64'(if0.out), 64'h0);
    chk("abort busy", 64'(if0.sweep_busy), 64'd0);
    rst = 1'b1;
    idle_all();
    for (int i = 0; i < 40; i++) begin
      step();
      chk("abort no done", 64'(if0.sweep_done), 64'd0);
    end

    // Randomized traffic on all instances.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 3; d++) rand_stim(d);
      rst = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
